vc_bus_responder: RTL
=====================

// Module: vc_bus_responder
// PURPOSE
//  Bus slave (target) for the VC CPU's byte-multiplexed external memory bus. It decodes the
//  controller's pin protocol: address high byte, address low byte, then 1-2 data bytes.
//  It backs the bus with a byte-wide RAM and returns read data on bus_out.
//  Used as the FPGA/bench companion to the tt_um CPU pins; also raises a doorbell interrupt.
// PARAMETERS
//  MEM_AW      10       byte-address bits of backing RAM (2^MEM_AW bytes); upper address bits ignored
//  DOORBELL    16'hFFFE word address (bit0=0) whose write sets irq_out; read of it clears irq_out
// PORTS
//  clk        in   1   clock, same clock as the CPU
//  rst_n      in   1   asynchronous active-low reset
//  bus_in     in   8   CPU uo_out: address/data byte
//  latch_lo   in   1   CPU uio_out[3]: bus_in[7:1] = address low bits
//  latch_hi   in   1   CPU uio_out[2]: bus_in = address high byte
//  write      in   1   CPU uio_out[1]: bus_in = write data byte
//  ind        in   1   CPU uio_out[0]: byte select, 0 = low byte, 1 = high byte
//  bus_out    out  8   to CPU ui_in: read data byte
//  irq_out    out  1   to CPU uio_in[7]: doorbell interrupt, level
//  err        out  1   sticky protocol error
//  rd_count   out  16  completed word reads, wraps at 0xFFFF->0
//  wr_count   out  16  written bytes, wraps
//  dbg_addr   in   MEM_AW  backdoor byte address, bench only
//  dbg_data   out  8   mem[dbg_addr], combinational
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; addr_hi=0; addr_lo=0; irq_out=0; err=0; counts=0.
//    RAM contents are not reset. bus_out follows its read equation.
//  - Byte index = {addr_hi, lo_eff, ind}[MEM_AW-1:0]. lo_eff = latch_lo ? bus_in[7:1] : addr_lo.
//    lo_eff is transparent, so the low byte is valid in the same cycle latch_lo is high.
//  - bus_out = mem[byte index]. Combinational, zero-latency async read; the CPU samples it at the
//    clock edge ending each read phase.
//  - All inputs are sampled at posedge clk. FSM:
//    IDLE: latch_hi -> addr_hi <= bus_in, go HI. write -> err <= 1, stay IDLE.
//    HI:   latch_lo -> addr_lo <= bus_in[7:1], go LO. latch_hi -> recapture addr_hi, stay HI.
//          write -> err <= 1, go IDLE. Otherwise stay HI.
//    LO:   write=1 -> mem[idx] <= bus_in, wr_count++, go WR.
//          write=0 -> read high-byte phase (ind=1 expected): rd_count++, go IDLE.
//          On a read of DOORBELL, irq_out <= 0. A read with ind=0 here sets err.
//    WR:   write=1 -> second byte: mem[idx] <= bus_in, wr_count++, stay WR.
//          A third consecutive write sets err; its byte is still written.
//          write=0 -> go IDLE.
//  - latch_hi in LO or WR: abort the current access, capture addr_hi, go HI.
//    No err; the aborted read is not counted.
//  - latch_hi and latch_lo both high in one cycle: err <= 1, capture both, go LO.
//  - Doorbell: any byte write whose word address {addr_hi, addr_lo} == DOORBELL[15:1] sets irq_out.
//    If a set and a clear land in the same cycle, the set wins.
//  - Write timing: a byte written at edge N is visible on bus_out and dbg_data from cycle N+1.
//  - Address above 2^MEM_AW aliases (wraps) into the RAM.
//  - rst_n asserted mid-access: the FSM returns to IDLE immediately.
//    A byte whose write edge has already occurred stays in RAM.
// TESTING
//  1. Word write 0x0124 <- 0xBEEF (wmask 11): hi=0x01, lo=0x24, write ind0 0xEF, ind1 0xBE
//     -> mem[0x124]=0xEF, mem[0x125]=0xBE, wr_count=2, err=0.
//  2. Read back word 0x0124: bus_out=0xEF during the latch_lo cycle, 0xBE in the next (ind=1)
//     -> rd_count=1.
//  3. Byte write 0x0301 <- 0x5A (ind=1 from latch_lo cycle) -> only mem[0x301] changes;
//     mem[0x300] is unchanged; wr_count increments by 1.
//  4. Write 0x1234 to DOORBELL 0xFFFE -> irq_out=1 next cycle.
//     A read of 0xFFFE -> irq_out=0 after the high-byte phase.
//  5. write pulse in IDLE, and latch_hi+latch_lo together -> err=1 and stays 1 until rst_n.
//  6. Reset pulse mid-write between the two data bytes -> FSM in IDLE, counts=0.
//     mem keeps the first byte; the next access decodes normally.

Source files
------------

// File: rtl/vc_bus_responder_if.sv
// rtl/vc_bus_responder_if.sv - VC CPU byte-multiplexed external memory bus pins
interface vc_bus_responder_if;
    logic [7:0] bus_in;
    logic       latch_lo;
    logic       latch_hi;
    logic       write;
    logic       ind;
    logic [7:0] bus_out;
    logic       irq_out;

    modport master (
        output bus_in, latch_lo, latch_hi, write, ind,
        input  bus_out, irq_out
    );

    modport slave (
        input  bus_in, latch_lo, latch_hi, write, ind,
        output bus_out, irq_out
    );
endinterface

// File: rtl/vc_bus_responder.sv
// rtl/vc_bus_responder.sv - byte-wide RAM target for the VC CPU external bus, with doorbell irq
module vc_bus_responder #(
    parameter int          MEM_AW   = 10,
    parameter logic [15:0] DOORBELL = 16'hFFFE
) (
    input  logic              clk,
    input  logic              rst_n,
    vc_bus_responder_if.slave bus,
    output logic              err,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
    input  logic [MEM_AW-1:0] dbg_addr,
    output logic [7:0]        dbg_data
);

    typedef enum logic [1:0] {IDLE, HI, LO, WR} state_t;

    state_t            state, state_n;
    logic [7:0]        addr_hi, addr_hi_n;
    logic [6:0]        addr_lo, addr_lo_n;
    logic              second, second_n;
    logic              irq_q;
    logic              err_set, rd_inc, wr_inc, mem_we, irq_set, irq_clr;
    logic [6:0]        lo_eff;
    logic [MEM_AW-1:0] idx;
    logic              db_hit;
    logic [7:0]        mem [0:(1<<MEM_AW)-1];

    // The low address is transparent so the CPU can read the low byte in the latch_lo cycle.
    assign lo_eff = bus.latch_lo ? bus.bus_in[7:1] : addr_lo;
    assign idx    = MEM_AW'({addr_hi, lo_eff, bus.ind});
    assign db_hit = ({addr_hi, addr_lo} == DOORBELL[15:1]);

    always_comb begin
        state_n   = state;
        addr_hi_n = addr_hi;
        addr_lo_n = addr_lo;
        second_n  = second;
        err_set   = 1'b0;
        rd_inc    = 1'b0;
        wr_inc    = 1'b0;
        mem_we    = 1'b0;
        irq_set   = 1'b0;
        irq_clr   = 1'b0;
        if (bus.latch_hi && bus.latch_lo) begin
            err_set   = 1'b1;
            addr_hi_n = bus.bus_in;
            addr_lo_n = bus.bus_in[7:1];
            state_n   = LO;
        end else if (bus.latch_hi) begin
            // A new high byte always restarts the access, aborting anything in flight.
            addr_hi_n = bus.bus_in;
            state_n   = HI;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.write) err_set = 1'b1;
                end
                HI: begin
                    if (bus.latch_lo) begin
                        addr_lo_n = bus.bus_in[7:1];
                        state_n   = LO;
                    end else if (bus.write) begin
                        err_set = 1'b1;
                        state_n = IDLE;
                    end
                end
                LO: begin
                    if (bus.write) begin
                        mem_we   = 1'b1;
                        wr_inc   = 1'b1;
                        irq_set  = db_hit;
                        second_n = 1'b0;
                        state_n  = WR;
                    end else begin
                        rd_inc  = 1'b1;
                        irq_clr = db_hit;
                        err_set = ~bus.ind;
                        state_n = IDLE;
                    end
                end
                WR: begin
                    if (bus.write) begin
                        mem_we   = 1'b1;
                        wr_inc   = 1'b1;
                        irq_set  = db_hit;
                        err_set  = second;
                        second_n = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr_hi  <= 8'h00;
            addr_lo  <= 7'h00;
            second   <= 1'b0;
            irq_q    <= 1'b0;
            err      <= 1'b0;
            rd_count <= 16'h0000;
            wr_count <= 16'h0000;
        end else begin
            state   <= state_n;
            addr_hi <= addr_hi_n;
            addr_lo <= addr_lo_n;
            second  <= second_n;
            if (irq_set)      irq_q <= 1'b1;
            else if (irq_clr) irq_q <= 1'b0;
            if (err_set) err <= 1'b1;
            if (rd_inc)  rd_count <= rd_count + 16'd1;
            if (wr_inc)  wr_count <= wr_count + 16'd1;
        end
    end

    // RAM contents survive reset; mem_we is only raised outside IDLE, so reset blocks writes.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= bus.bus_in;
    end

    assign bus.bus_out = mem[idx];
    assign bus.irq_out = irq_q;
    assign dbg_data    = mem[dbg_addr];

endmodule
